// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared widths, instruction field positions, opcode encoding
//                and controller state encoding for the register-file
//                sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int W       = 16;   // data width, matches the 8x16 register file
    localparam int AW      = 3;    // register address width
    localparam int INSTR_W = 16;
    localparam int OP_W    = 4;
    localparam int IMM_W   = 9;

    // Instruction field bit positions
    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 12;
    localparam int DST_MSB  = 11;
    localparam int DST_LSB  = 9;
    localparam int SRCA_MSB = 8;
    localparam int SRCA_LSB = 6;
    localparam int SRCB_MSB = 5;
    localparam int SRCB_LSB = 3;
    localparam int IMM_MSB  = 8;
    localparam int IMM_LSB  = 0;

    // Opcode encoding; 11-15 are illegal
    localparam logic [OP_W-1:0] OP_NOP = 4'd0;
    localparam logic [OP_W-1:0] OP_MOV = 4'd1;
    localparam logic [OP_W-1:0] OP_ADD = 4'd2;
    localparam logic [OP_W-1:0] OP_SUB = 4'd3;
    localparam logic [OP_W-1:0] OP_AND = 4'd4;
    localparam logic [OP_W-1:0] OP_OR  = 4'd5;
    localparam logic [OP_W-1:0] OP_XOR = 4'd6;
    localparam logic [OP_W-1:0] OP_NOT = 4'd7;
    localparam logic [OP_W-1:0] OP_SHL = 4'd8;
    localparam logic [OP_W-1:0] OP_SHR = 4'd9;
    localparam logic [OP_W-1:0] OP_LDI = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/regfile_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_seq_if
//  Description : Instruction valid/ready handshake bundle.
//                master : instruction source (drives instr_valid, instr)
//                slave  : sequencer (drives instr_ready)
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_seq_if;
    import regfile_pkg::*;

    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;

    modport master (output instr_valid, output instr, input instr_ready);
    modport slave  (input instr_valid, input instr, output instr_ready);

endinterface
`default_nettype wire

// File: rtl/regfile_alu.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_alu
//  Description : Combinational ALU for the register-file sequencer.
//                Ports: op (opcode), a/b (operands), imm (LDI immediate),
//                result ({carry, data}), flag_en (op updates flags/writes).
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_alu #(
    parameter int W = regfile_pkg::W
) (
    input  wire logic [regfile_pkg::OP_W-1:0]  op,
    input  wire logic [W-1:0]                  a,
    input  wire logic [W-1:0]                  b,
    input  wire logic [regfile_pkg::IMM_W-1:0] imm,
    output logic      [W:0]                    result,
    output logic                               flag_en
);
    import regfile_pkg::*;

    always_comb begin
        result  = '0;
        flag_en = 1'b1;
        case (op)
            OP_MOV: result = {1'b0, a};
            OP_ADD: result = {1'b0, a} + {1'b0, b};
            // A + ~B + 1: carry out is set exactly when no borrow occurs
            OP_SUB: result = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
            OP_AND: result = {1'b0, a & b};
            OP_OR:  result = {1'b0, a | b};
            OP_XOR: result = {1'b0, a ^ b};
            OP_NOT: result = {1'b0, ~a};
            OP_SHL: result = {a, 1'b0};
            OP_SHR: result = {a[0], 1'b0, a[W-1:1]};
            OP_LDI: result = (W+1)'(imm);
            // NOP and illegal opcodes: no write, flags untouched
            default: flag_en = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/regfile_seq.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_seq
//  Description : Sequencing controller for the 8x16 register file.
//                IDLE -> READ -> EXEC -> WRITE -> IDLE, one instruction at a
//                time, with run / single-step gating of the non-IDLE states.
//                Ports: clk, rst (async, active high); instr_if (valid/ready
//                instruction handshake); run, step_req (step control);
//                rf_rd_a/b, rf_oper_a/b (read port); rf_wt_adrs, rf_wt_data,
//                rf_write, rf_step (write port); busy, done, flag_z, flag_c.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_seq #(
    parameter int W  = regfile_pkg::W,
    parameter int AW = regfile_pkg::AW
) (
    input  wire logic          clk,
    input  wire logic          rst,
    regfile_seq_if.slave       instr_if,
    input  wire logic          run,
    input  wire logic          step_req,
    output logic      [AW-1:0] rf_rd_a,
    output logic      [AW-1:0] rf_rd_b,
    input  wire logic [W-1:0]  rf_oper_a,
    input  wire logic [W-1:0]  rf_oper_b,
    output logic      [AW-1:0] rf_wt_adrs,
    output logic      [W-1:0]  rf_wt_data,
    output logic               rf_write,
    output logic               rf_step,
    output logic               busy,
    output logic               done,
    output logic               flag_z,
    output logic               flag_c
);
    import regfile_pkg::*;

    state_t             state_q,   state_d;
    logic [INSTR_W-1:0] instr_q,   instr_d;
    logic [W-1:0]       op_a_q,    op_a_d;
    logic [W-1:0]       op_b_q,    op_b_d;
    logic [AW-1:0]      rd_a_q,    rd_a_d;
    logic [AW-1:0]      rd_b_q,    rd_b_d;
    logic [AW-1:0]      wt_adrs_q, wt_adrs_d;
    logic [W-1:0]       wt_data_q, wt_data_d;
    logic               flag_z_q,  flag_z_d;
    logic               flag_c_q,  flag_c_d;
    logic               done_q,    done_d;

    logic [W:0]         alu_result;
    logic               alu_flag_en;
    logic               adv;

    // Non-IDLE states advance every edge when free-running, otherwise only
    // on an edge that carries a step request.
    assign adv = run | step_req;

    regfile_alu #(.W(W)) u_alu (
        .op      (instr_q[OP_MSB:OP_LSB]),
        .a       (op_a_q),
        .b       (op_b_q),
        .imm     (instr_q[IMM_MSB:IMM_LSB]),
        .result  (alu_result),
        .flag_en (alu_flag_en)
    );

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        rd_a_d    = rd_a_q;
        rd_b_d    = rd_b_q;
        wt_adrs_d = wt_adrs_q;
        wt_data_d = wt_data_q;
        flag_z_d  = flag_z_q;
        flag_c_d  = flag_c_q;
        done_d    = 1'b0;
        rf_write  = 1'b0;
        rf_step   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (instr_if.instr_valid) begin
                    instr_d = instr_if.instr;
                    // Read addresses are presented for the whole READ cycle
                    rd_a_d  = AW'(instr_if.instr[SRCA_MSB:SRCA_LSB]);
                    rd_b_d  = AW'(instr_if.instr[SRCB_MSB:SRCB_LSB]);
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (adv) begin
                    // Operands captured here, so dst == src is safe
                    op_a_d  = rf_oper_a;
                    op_b_d  = rf_oper_b;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (adv) begin
                    if (alu_flag_en) begin
                        flag_z_d  = (alu_result[W-1:0] == '0);
                        flag_c_d  = alu_result[W];
                        wt_adrs_d = AW'(instr_q[DST_MSB:DST_LSB]);
                        wt_data_d = alu_result[W-1:0];
                    end
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // Strobe only in the cycle that leaves WRITE so single-step
                // produces exactly one write per instruction.
                if (adv) begin
                    rf_step  = 1'b1;
                    rf_write = alu_flag_en;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            instr_q   <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            rd_a_q    <= '0;
            rd_b_q    <= '0;
            wt_adrs_q <= '0;
            wt_data_q <= '0;
            flag_z_q  <= 1'b0;
            flag_c_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            rd_a_q    <= rd_a_d;
            rd_b_q    <= rd_b_d;
            wt_adrs_q <= wt_adrs_d;
            wt_data_q <= wt_data_d;
            flag_z_q  <= flag_z_d;
            flag_c_q  <= flag_c_d;
            done_q    <= done_d;
        end
    end

    assign instr_if.instr_ready = (state_q == ST_IDLE);
    assign busy                 = (state_q != ST_IDLE);
    assign done                 = done_q;
    assign rf_rd_a              = rd_a_q;
    assign rf_rd_b              = rd_b_q;
    assign rf_wt_adrs           = wt_adrs_q;
    assign rf_wt_data           = wt_data_q;
    assign flag_z               = flag_z_q;
    assign flag_c               = flag_c_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_seq
//  Description : Directed self-checking bench for regfile_seq with a small
//                8x16 register file model attached to its read/write ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_seq;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        run      = 1'b1;
    logic        step_req = 1'b0;
    logic [2:0]  rf_rd_a, rf_rd_b, rf_wt_adrs;
    logic [15:0] rf_oper_a, rf_oper_b, rf_wt_data;
    logic        rf_write, rf_step, busy, done, flag_z, flag_c;

    logic [15:0] mem [8] = '{default: 16'h0000};
    int          cyc      = 0;
    int          acc_cyc  = 0;
    int          wr_cyc   = 0;
    int          wr_cnt   = 0;
    int          done_cnt = 0;
    logic [2:0]  wr_addr  = 3'd0;
    logic [15:0] wr_data  = 16'h0000;

    int n_assert = 0;
    int n_fail   = 0;

    regfile_seq_if ifc ();

    regfile_seq #(.W(16), .AW(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_if   (ifc.slave),
        .run        (run),
        .step_req   (step_req),
        .rf_rd_a    (rf_rd_a),
        .rf_rd_b    (rf_rd_b),
        .rf_oper_a  (rf_oper_a),
        .rf_oper_b  (rf_oper_b),
        .rf_wt_adrs (rf_wt_adrs),
        .rf_wt_data (rf_wt_data),
        .rf_write   (rf_write),
        .rf_step    (rf_step),
        .busy       (busy),
        .done       (done),
        .flag_z     (flag_z),
        .flag_c     (flag_c)
    );

    always #5 clk = ~clk;

    assign rf_oper_a = mem[rf_rd_a];
    assign rf_oper_b = mem[rf_rd_b];

    // Register file model and event log
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ifc.instr_valid && ifc.instr_ready) acc_cyc <= cyc;
        if (rf_write && rf_step) begin
            mem[rf_wt_adrs] <= rf_wt_data;
            wr_addr         <= rf_wt_adrs;
            wr_data         <= rf_wt_data;
            wr_cyc          <= cyc;
            wr_cnt          <= wr_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] ins);
        ifc.instr       = ins;
        ifc.instr_valid = 1'b1;
        tick();
        ifc.instr_valid = 1'b0;
    endtask

    task automatic run_instr(input string tag, input logic [15:0] ins);
        int k;
        issue(ins);
        k = 0;
        while (done !== 1'b1 && k < 12) begin
            tick();
            k++;
        end
        check({tag, " done"}, {31'd0, done}, 32'd1);
    endtask

    task automatic check_wr(input string tag, input logic [2:0] addr, input logic [15:0] data,
                            input logic z, input logic c);
        check({tag, " wr_addr"}, {29'd0, wr_addr}, {29'd0, addr});
        check({tag, " wr_data"}, {16'd0, wr_data}, {16'd0, data});
        check({tag, " mem"}, {16'd0, mem[addr]}, {16'd0, data});
        check({tag, " flag_z"}, {31'd0, flag_z}, {31'd0, z});
        check({tag, " flag_c"}, {31'd0, flag_c}, {31'd0, c});
        check({tag, " latency"}, wr_cyc - acc_cyc, 32'd3);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " instr_ready"}, {31'd0, ifc.instr_ready}, 32'd1);
        check({tag, " busy"}, {31'd0, busy}, 32'd0);
        check({tag, " done"}, {31'd0, done}, 32'd0);
        check({tag, " rf_write/step"}, {30'd0, rf_write, rf_step}, 32'd0);
        check({tag, " rd_a/rd_b"}, {26'd0, rf_rd_a, rf_rd_b}, 32'd0);
        check({tag, " wt_adrs"}, {29'd0, rf_wt_adrs}, 32'd0);
        check({tag, " wt_data"}, {16'd0, rf_wt_data}, 32'd0);
        check({tag, " flags"}, {30'd0, flag_z, flag_c}, 32'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int acc1;
        ifc.instr_valid = 1'b0;
        ifc.instr       = 16'h0000;

        // Reset state
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // LDI r1,0x1FF ; LDI r2,0x001 ; ADD r3,r1,r2
        base = done_cnt;
        run_instr("ldi1", 16'hA3FF);
        check_wr("ldi1", 3'd1, 16'h01FF, 1'b0, 1'b0);
        acc1 = acc_cyc;
        run_instr("ldi2", 16'hA401);
        check_wr("ldi2", 3'd2, 16'h0001, 1'b0, 1'b0);
        check("throughput", acc_cyc - acc1, 32'd4);
        run_instr("add", 16'h2650);
        check_wr("add", 3'd3, 16'h0200, 1'b0, 1'b0);
        tick();
        check("done_pulses", done_cnt - base, 32'd3);

        // Carry / zero: r1 = NOT r0 = 0xFFFF
        run_instr("not", 16'h7200);
        check_wr("not", 3'd1, 16'hFFFF, 1'b0, 1'b0);
        run_instr("add_cz", 16'h2850);
        check_wr("add_cz", 3'd4, 16'h0000, 1'b1, 1'b1);
        run_instr("and", 16'h4C48);
        check_wr("and", 3'd6, 16'hFFFF, 1'b0, 1'b0);
        run_instr("sub", 16'h3A90);
        check_wr("sub", 3'd5, 16'h0000, 1'b1, 1'b1);

        // Build r1 = 0x8001 then shift it
        run_instr("shl_ff", 16'h8C40);
        check_wr("shl_ff", 3'd6, 16'hFFFE, 1'b0, 1'b1);
        run_instr("shr_ff", 16'h9E40);
        check_wr("shr_ff", 3'd7, 16'h7FFF, 1'b0, 1'b1);
        run_instr("xor", 16'h63B8);
        check_wr("xor", 3'd1, 16'h8001, 1'b0, 1'b0);
        run_instr("shl", 16'h8C40);
        check_wr("shl", 3'd6, 16'h0002, 1'b0, 1'b1);
        run_instr("shr", 16'h9E40);
        check_wr("shr", 3'd7, 16'h4000, 1'b0, 1'b1);

        // Illegal op 13
        base = wr_cnt;
        issue(16'hD000);
        check("ill busy1", {31'd0, busy}, 32'd1);
        tick();
        check("ill busy2", {31'd0, busy}, 32'd1);
        tick();
        check("ill busy3", {31'd0, busy}, 32'd1);
        check("ill ready", {31'd0, ifc.instr_ready}, 32'd0);
        check("ill rf_write", {31'd0, rf_write}, 32'd0);
        tick();
        check("ill idle", {30'd0, busy, done}, 32'd1);
        check("ill no write", wr_cnt - base, 32'd0);
        check("ill flags", {30'd0, flag_z, flag_c}, 32'd1);

        // Single-step MOV r0,r3
        run = 1'b0;
        tick();
        base = wr_cnt;
        issue(16'h10C0);
        check("ss read busy", {31'd0, busy}, 32'd1);
        check("ss rd_a", {29'd0, rf_rd_a}, 32'd3);
        ifc.instr       = 16'hA3FF;
        ifc.instr_valid = 1'b1;
        tick();
        tick();
        ifc.instr_valid = 1'b0;
        check("ss ignore valid", {28'd0, busy, rf_rd_a}, 32'h0000000B);
        tick();
        step_req = 1'b1;
        #1;
        check("ss read no write", {31'd0, rf_write}, 32'd0);
        tick();
        step_req = 1'b0;
        tick();
        tick();
        check("ss exec wait", {30'd0, busy, rf_write}, 32'd2);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        tick();
        check("ss write wait", {30'd0, rf_write, rf_step}, 32'd0);
        check("ss flags", {30'd0, flag_z, flag_c}, 32'd0);
        check("ss no write yet", wr_cnt - base, 32'd0);
        step_req = 1'b1;
        #1;
        check("ss strobe", {30'd0, rf_write, rf_step}, 32'd3);
        check("ss wt_adrs", {29'd0, rf_wt_adrs}, 32'd0);
        check("ss wt_data", {16'd0, rf_wt_data}, 32'h00000200);
        tick();
        step_req = 1'b0;
        check("ss done", {30'd0, busy, done}, 32'd1);
        check("ss one write", wr_cnt - base, 32'd1);
        check("ss r0", {16'd0, mem[0]}, 32'h00000200);
        check("ss r1 kept", {16'd0, mem[1]}, 32'h00008001);

        // Reset in the middle of EXEC of an ADD
        run = 1'b1;
        tick();
        run_instr("sub2", 16'h3A90);
        check_wr("sub2", 3'd5, 16'h0000, 1'b1, 1'b1);
        base = wr_cnt;
        issue(16'h2850);
        tick();
        check("rst exec busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst mid");
        tick();
        tick();
        rst = 1'b0;
        check("rst no write", wr_cnt - base, 32'd0);
        check("rst r4 kept", {16'd0, mem[4]}, 32'd0);
        tick();
        run_instr("add_after", 16'h2850);
        check_wr("add_after", 3'd4, 16'h8002, 1'b0, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_seq.md
# regfile_seq

Sequencing controller for the 8x16 register file. Accepts one instruction at a time over a valid/ready handshake and drives the register file read and write ports. Reads two operands, computes the result in an internal 16-bit ALU, and writes it back with a one-cycle write strobe. A run/single-step mode lets the lab board advance the sequence one state per step request.

## Interface
- `W`, default 16: data width; must match the register file.
- `AW`, default 3: register address width (8 registers).
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `instr_valid` in 1: an instruction is present on `instr`.
- `instr_ready` out 1: controller is able to accept an instruction.
- `instr` in 16: instruction word.
  - [15:12] op
  - [11:9] dst
  - [8:6] srcA
  - [5:3] srcB
  - [8:0] imm (LDI only)
- `run` in 1: 1 = free-running; 0 = single-step.
- `step_req` in 1: one-cycle pulse (already debounced) that advances a state in single-step mode.
- `rf_rd_a`, `rf_rd_b` out AW: register file read addresses.
- `rf_oper_a`, `rf_oper_b` in W: register file read data, combinational from the addresses.
- `rf_wt_adrs` out AW: register file write address.
- `rf_wt_data` out W: register file write data.
- `rf_write`, `rf_step` out 1: register file write qualifiers; the register file writes when both are 1.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse on return to IDLE after an instruction.
- `flag_z`, `flag_c` out 1: zero and carry flags.

## Operation
- States: IDLE, READ, EXEC, WRITE.
- IDLE:
  - `instr_ready`=1.
  - When `instr_valid`=1, latch `instr` and go to READ. No step is required to accept.
- READ:
  - `rf_rd_a`=srcA and `rf_rd_b`=srcB, from the latched fields.
  - Latch `rf_oper_a`/`rf_oper_b` into opA/opB on leaving READ.
- EXEC:
  - Compute a 17-bit result {c,r} and register it.
  - Update flags.
- WRITE:
  - `rf_step`=1 and `rf_write`=1 (write qualifier), `rf_wt_adrs`=dst, `rf_wt_data`=r.
  - Then go to IDLE and pulse `done`.
- Op encoding:
  - 0 NOP
  - 1 MOV r=A
  - 2 ADD A+B, c=carry out
  - 3 SUB A-B, c=1 when no borrow
  - 4 AND
  - 5 OR
  - 6 XOR
  - 7 NOT A
  - 8 SHL A by 1, c=A[15]
  - 9 SHR A by 1 (logical), c=A[0]
  - 10 LDI r={7'b0,imm}
  - 11-15 illegal
- Flags:
  - `flag_z`=(r==0) for ops 1-10.
  - `flag_c` is set by ops 2, 3, 8 and 9, and cleared by ops 1, 4-7 and 10.
  - NOP and illegal ops leave both flags unchanged.
- NOP and illegal ops still traverse all states but hold `rf_write`=0 in WRITE.
- Outside WRITE: `rf_write`=0 and `rf_step`=0. Address and data outputs hold their last driven values.
- Single-step (`run`=0): READ→EXEC, EXEC→WRITE and WRITE→IDLE each occur only on an edge where `step_req`=1. The WRITE strobe is asserted only in the cycle that advances out of WRITE.
- `run` may change at any time; it takes effect on the next edge.

## Timing
- Reset values:
  - state=IDLE
  - `instr_ready`=1, `busy`=0, `done`=0
  - `rf_write`=0, `rf_step`=0
  - `rf_rd_a`=`rf_rd_b`=`rf_wt_adrs`=0, `rf_wt_data`=0
  - `flag_z`=0, `flag_c`=0
- Free-run latency: accept on edge N; register file write on edge N+3; `done`=1 during the cycle after edge N+3. The next instruction can be accepted on edge N+4.
- Throughput is 1 instruction per 4 cycles.
- `instr_ready` is 0 in all non-IDLE states. `instr_valid` is ignored while busy.
- `rst` asserted mid-instruction: immediate return to IDLE, no register file write, the pending instruction is dropped, and flags clear.
- dst equal to srcA (e.g. ADD r1,r1,r2) is legal: operands are latched in READ, before the write.

## Structure
- Shared package `regfile_pkg`:
  - W and AW
  - the op encoding constants
  - the state encoding
  - instruction field bit positions
- Sub-module `regfile_alu`: combinational; inputs op, A, B, imm; outputs the 17-bit result and a flag-update enable. Instantiated once.
- The FSM, latches and step gating live in `regfile_seq`.

## Test plan
- **Reset:** assert `rst` mid-EXEC of ADD → no `rf_write` pulse, all outputs at reset values, `instr_ready`=1.
- **LDI then ADD:** LDI r1,0x1FF; LDI r2,0x001; ADD r3,r1,r2.
  - Each write lands 3 edges after its accept.
  - Final write is r3=0x0200 with `flag_c`=0 and `flag_z`=0; `done` pulses 3 times.
- **Carry/zero:** with r1=0xFFFF and r2=0x0001, ADD r4,r1,r2 → r4=0x0000, `flag_c`=1, `flag_z`=1. Then SUB r5,r2,r2 → r5=0, `flag_c`=1, `flag_z`=1.
- **Shifts:** with r1=0x8001:
  - SHL r6,r1 → r6=0x0002, `flag_c`=1.
  - SHR r7,r1 → r7=0x4000, `flag_c`=1.
- **Illegal/NOP:** op 13 → `busy` for 3 cycles, no `rf_write`, flags unchanged, `done` pulses.
- **Single-step:** `run`=0, then MOV r0,r3.
  - FSM waits in READ until `step_req`; write occurs only on the third `step_req`.
  - `instr_valid` pulses while busy are ignored.
